// File: rtl/prog_load_sequencer.sv
// prog_load_sequencer: packs 64-bit host words into 512-bit lines and issues one AW+W per line on the RAM load port (optional PROG_LOAD_CHECKSUM_EN adds a running word checksum)
module prog_load_sequencer #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 512,
  parameter int WORD_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    line_count,
  input  logic                    s_word_valid,
  output logic                    s_word_ready,
  input  logic [WORD_WIDTH-1:0]   s_word_data,
  output logic                    load_en,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    lines_written,
  output logic [31:0]             checksum
);
  localparam int BEATS = DATA_WIDTH / WORD_WIDTH;
  localparam int BW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, lines_q, lines_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic word_hs, accept;
  assign s_word_ready  = state_q == FILL;
  assign load_en       = state_q == FILL || state_q == ISSUE;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign aw_valid      = state_q == ISSUE && aw_pend_q;
  assign w_valid       = state_q == ISSUE && w_pend_q;
  assign aw_addr       = base_q + ADDR_WIDTH'({lines_q, 6'd0});
  assign w_data        = data_q;
  assign w_strb        = '1;
  assign lines_written = lines_q;
  assign word_hs       = s_word_ready && s_word_valid && !abort;
  assign accept        = state_q == IDLE && start && !abort;
  // next-state: abort overrides everything; each channel's pending flag clears on its own handshake
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    count_d   = count_q;
    lines_d   = lines_q;
    data_d    = data_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    if (abort) begin
      state_d   = IDLE;
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = line_count == '0 ? DONE : FILL;
          base_d  = base_addr & ~ADDR_WIDTH'(63);
          count_d = line_count;
          lines_d = '0;
          beat_d  = '0;
        end
        FILL: if (word_hs) begin
          data_d[beat_q*WORD_WIDTH +: WORD_WIDTH] = s_word_data;
          beat_d = beat_q == BW'(BEATS-1) ? '0 : beat_q + 1'b1;
          if (beat_q == BW'(BEATS-1)) begin
            state_d   = ISSUE;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end
        end
        ISSUE: begin
          aw_pend_d = aw_pend_q && !aw_ready;
          w_pend_d  = w_pend_q && !w_ready;
          if (!aw_pend_d && !w_pend_d) begin
            lines_d = lines_q + 1'b1;
            state_d = lines_d == count_q ? DONE : FILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      count_q   <= '0;
      lines_q   <= '0;
      data_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      count_q   <= count_d;
      lines_q   <= lines_d;
      data_q    <= data_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
  // running sum of both word halves, restarted by an accepted start
  always_comb checksum_d = accept ? '0 : word_hs ? checksum_q + s_word_data[31:0] + s_word_data[63:32] : checksum_q;
  // checksum register
  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_prog_load_sequencer.sv
// tb_prog_load_sequencer: scoreboard bench for prog_load_sequencer
module tb_prog_load_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [14:0] base_addr = '0;
  logic [15:0] line_count = '0;
  logic s_word_valid = 0, s_word_ready;
  logic [63:0] s_word_data = '0;
  logic load_en, aw_valid, aw_ready = 1, w_valid, w_ready = 1, busy, done;
  logic [14:0] aw_addr;
  logic [511:0] w_data;
  logic [63:0] w_strb;
  logic [15:0] lines_written;
  logic [31:0] checksum;
  int n_chk = 0, n_fail = 0;
  int n_load = 0, n_done = 0, n_valid = 0;
  int aw_run = 0, w_run = 0, aw_last = 0, w_last = 0;
  logic [14:0] aw_prev;
  logic [511:0] w_prev;
  logic [14:0] exp_aw[$];
  logic [511:0] exp_w[$];
  logic [15:0] exp_done[$];

  prog_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .line_count(line_count), .s_word_valid(s_word_valid), .s_word_ready(s_word_ready),
    .s_word_data(s_word_data), .load_en(load_en), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .aw_addr(aw_addr), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .busy(busy), .done(done), .lines_written(lines_written), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_en) n_load++;
    if (aw_valid || w_valid) n_valid++;
    if (done) begin
      n_done++;
      if (exp_done.size() == 0) check("unexpected_done", 1, 0);
      else check("lines_at_done", lines_written, exp_done.pop_front());
    end
    if (aw_valid) begin
      if (aw_run > 0) check("aw_addr_stable", aw_addr, aw_prev);
      aw_prev = aw_addr;
      aw_run++;
      if (aw_ready) begin
        if (exp_aw.size() == 0) check("unexpected_aw", 1, 0);
        else check("aw_addr", aw_addr, exp_aw.pop_front());
      end
    end else if (aw_run > 0) begin
      aw_last = aw_run;
      aw_run = 0;
    end
    if (w_valid) begin
      if (w_run > 0) check("w_data_stable", w_data, w_prev);
      w_prev = w_data;
      w_run++;
      if (w_ready) begin
        if (exp_w.size() == 0) check("unexpected_w", 1, 0);
        else check("w_data", w_data, exp_w.pop_front());
      end
    end else if (w_run > 0) begin
      w_last = w_run;
      w_run = 0;
    end
  end

  function automatic logic [511:0] mkline(input logic [7:0] tag);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = {24'h0, tag, 32'(k + 1)};
    return r;
  endfunction

  task automatic push_word(input logic [63:0] d);
    bit ok = 0;
    s_word_valid = 1;
    s_word_data = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_word_ready) begin ok = 1; break; end
    end
    check("word_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [511:0] line, input int nw);
    for (int k = 0; k < nw; k++) push_word(line[64*k +: 64]);
    s_word_valid = 0;
  endtask

  task automatic go(input logic [14:0] b, input logic [15:0] c);
    base_addr = b;
    line_count = c;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int n0);
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (n_done != n0) begin ok = 1; break; end
    end
    check("done_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, l0, v0;
    logic [511:0] ln;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load_en", load_en, 0);
    check("rst_valids", {aw_valid, w_valid, s_word_ready}, 0);
    check("rst_aw_addr", aw_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_lines", lines_written, 0);
    check("rst_checksum", checksum, 0);
    check("w_strb", w_strb, {64{1'b1}});
    rst = 0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) ln[64*k +: 64] = 64'h1111 * (k + 1);
    exp_aw.push_back(15'h0100); exp_w.push_back(ln); exp_done.push_back(16'd1);
    n0 = n_done; l0 = n_load;
    go(15'h0100, 16'd1);
    feed(ln, 8);
    wait_done(n0);
    check("t1_load_cycles", n_load - l0, 9);
    check("t1_done_count", n_done - n0, 1);
    check("t1_lines", lines_written, 1);
    check("t1_w_lo", w_data[63:0], 64'h1111);
    check("t1_w_hi", w_data[511:448], 64'h8888);
    check("t1_busy_after", busy, 0);

    exp_aw.push_back(15'h7FC0); exp_aw.push_back(15'h0000); exp_aw.push_back(15'h0040);
    for (int l = 0; l < 3; l++) exp_w.push_back(mkline(8'(8'h20 + l)));
    exp_done.push_back(16'd3);
    n0 = n_done;
    go(15'h7FFF, 16'd3);
    for (int l = 0; l < 3; l++) feed(mkline(8'(8'h20 + l)), 8);
    wait_done(n0);
    check("t2_lines", lines_written, 3);

    exp_aw.push_back(15'h0000); exp_w.push_back(mkline(8'h30)); exp_done.push_back(16'd1);
    n0 = n_done;
    aw_ready = 0;
    go(15'h0000, 16'd1);
    feed(mkline(8'h30), 8);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    aw_ready = 1;
    wait_done(n0);
    check("t3_aw_run", aw_last, 6);
    check("t3_w_run", w_last, 1);
    check("t3_lines", lines_written, 1);

    exp_done.push_back(16'd0);
    n0 = n_done; l0 = n_load; v0 = n_valid;
    base_addr = 15'h0040; line_count = 16'd0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("t4_done_timing", done, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_done_count", n_done - n0, 1);
    check("t4_no_load_en", n_load - l0, 0);
    check("t4_no_valids", n_valid - v0, 0);

    exp_aw.push_back(15'h0000); exp_w.push_back(mkline(8'h40));
    n0 = n_done;
    go(15'h0000, 16'd4);
    feed(mkline(8'h40), 8);
    feed(mkline(8'h41), 5);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("t5_busy", busy, 0);
    check("t5_load_en", load_en, 0);
    check("t5_valids", {aw_valid, w_valid, s_word_ready}, 0);
    check("t5_lines", lines_written, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_done", n_done - n0, 0);
    exp_aw.push_back(15'h0200); exp_w.push_back(mkline(8'h50)); exp_done.push_back(16'd1);
    go(15'h0200, 16'd1);
    feed(mkline(8'h50), 8);
    wait_done(n0);
    check("t5_restart_lines", lines_written, 1);

    ln = {8{64'h00000001_00000002}};
    exp_aw.push_back(15'h0000); exp_w.push_back(ln); exp_done.push_back(16'd1);
    n0 = n_done;
    go(15'h0000, 16'd1);
    feed(ln, 8);
    wait_done(n0);
`ifdef PROG_LOAD_CHECKSUM_EN
    check("t6_checksum", checksum, 32'd24);
`else
    check("t6_checksum", checksum, 32'd0);
`endif
    check("queues_empty", exp_aw.size() + exp_w.size() + exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
